// File: rtl/sad_scan_ctrl.sv
// Raster scan controller that sweeps template candidates through compute_sad and tracks the best match.
// Optional feature: define SAD_EARLY_EXIT_EN to stop the scan as soon as a zero SAD is found.
module sad_scan_ctrl #(
    parameter logic [10:0] X_LAST = 11'd608,
    parameter logic [10:0] Y_LAST = 11'd448
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_start,
    output logic        fetch_req,
    input  logic        fetch_ack,
    output logic [10:0] cand_x,
    output logic [10:0] cand_y,
    output logic        sad_start,
    input  logic        sad_done,
    input  logic [10:0] sad_posx,
    input  logic [31:0] sad_val,
    output logic [10:0] best_x,
    output logic [10:0] best_y,
    output logic [31:0] best_sad,
    output logic        scan_busy,
    output logic        scan_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0] state;
    logic       at_x_last;
    logic       at_y_last;
    logic       stop_early;
    logic       unused_posx;

    // compute_sad only ever reports an offset of 0..3 within the 4-wide group
    assign unused_posx = ^sad_posx[10:2];

    assign at_x_last = (cand_x == X_LAST);
    assign at_y_last = (cand_y == Y_LAST);

`ifdef SAD_EARLY_EXIT_EN
    // best_sad is reloaded to all-ones at scan start, so zero here means this scan hit a perfect match
    assign stop_early = (best_sad == 32'd0);
`else
    assign stop_early = 1'b0;
`endif

    assign fetch_req = (state == FETCH);
    assign sad_start = (state == START);
    assign scan_done = (state == DONE);
    assign scan_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cand_x   <= 11'd0;
            cand_y   <= 11'd0;
            best_x   <= 11'd0;
            best_y   <= 11'd0;
            best_sad <= 32'hFFFF_FFFF;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        cand_x   <= 11'd0;
                        cand_y   <= 11'd0;
                        best_x   <= 11'd0;
                        best_y   <= 11'd0;
                        best_sad <= 32'hFFFF_FFFF;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_ack) begin
                        state <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (sad_done) begin
                        // strict compare keeps the first candidate found on ties
                        if (sad_val < best_sad) begin
                            best_sad <= sad_val;
                            best_x   <= cand_x + {9'd0, sad_posx[1:0]};
                            best_y   <= cand_y;
                        end
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if ((at_x_last && at_y_last) || stop_early) begin
                        state <= DONE;
                    end else if (at_x_last) begin
                        cand_x <= 11'd0;
                        cand_y <= cand_y + 11'd1;
                        state  <= FETCH;
                    end else begin
                        cand_x <= cand_x + 11'd4;
                        state  <= FETCH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_scan_ctrl.sv
// Directed bench for sad_scan_ctrl on a 3x2 candidate window with behavioural fetch and compute_sad models.
module tb_sad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_start;
    logic        fetch_req;
    logic        fetch_ack;
    logic [10:0] cand_x;
    logic [10:0] cand_y;
    logic        sad_start;
    logic        model_done;
    logic        spur_done;
    wire         sad_done = model_done | spur_done;
    logic [10:0] sad_posx;
    logic [31:0] sad_val;
    logic [10:0] best_x;
    logic [10:0] best_y;
    logic [31:0] best_sad;
    logic        scan_busy;
    logic        scan_done;

    int vectors = 0;
    int miscompares = 0;

    int start_cnt = 0;
    int base = 0;
    int done_cnt = 0;
    int stall_cyc = 0;
    int mk;
    int lat;
    logic stall_en = 1'b0;
    logic [31:0] tbl [6];
    logic [10:0] log_x [64];
    logic [10:0] log_y [64];

    sad_scan_ctrl #(.X_LAST(11'd8), .Y_LAST(11'd1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_start (scan_start),
        .fetch_req  (fetch_req),
        .fetch_ack  (fetch_ack),
        .cand_x     (cand_x),
        .cand_y     (cand_y),
        .sad_start  (sad_start),
        .sad_done   (sad_done),
        .sad_posx   (sad_posx),
        .sad_val    (sad_val),
        .best_x     (best_x),
        .best_y     (best_y),
        .best_sad   (best_sad),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    // compute_sad model: done 36 cycles after each start, SAD taken from the per-scan table
    initial begin
        model_done = 1'b0;
        sad_val    = 32'd0;
        sad_posx   = 11'd0;
        forever begin
            @(negedge clk);
            if (sad_start) begin
                if (start_cnt < 64) begin
                    log_x[start_cnt] = cand_x;
                    log_y[start_cnt] = cand_y;
                end
                mk = (start_cnt - base) % 6;
                start_cnt++;
                repeat (35) @(negedge clk);
                sad_val    = tbl[mk];
                sad_posx   = 11'd2;
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // fetch model: FETCH lasts lat+1 cycles; candidate (4,0) stalls to 10 cycles when enabled
    initial begin
        fetch_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (fetch_req && !fetch_ack) begin
                lat = (stall_en && cand_x == 11'd4 && cand_y == 11'd0) ? 9 : 1;
                repeat (lat) @(negedge clk);
                fetch_ack = 1'b1;
                @(negedge clk);
                fetch_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (scan_done) done_cnt++;
            if (fetch_req && cand_x == 11'd4 && cand_y == 11'd0) stall_cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_tbl(input logic [31:0] a, b, c, d, e, f);
        tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d; tbl[4] = e; tbl[5] = f;
    endtask

    task automatic begin_scan();
        base = start_cnt;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        chk("fetch_after_start", {31'd0, fetch_req}, 32'd1);
        chk("busy_after_start", {31'd0, scan_busy}, 32'd1);
        chk("best_sad_cleared", best_sad, 32'hFFFF_FFFF);
        chk("cand_cleared", {10'd0, cand_x, cand_y}, 32'd0);
    endtask

    task automatic finish_scan(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scan_done_pulses", done_cnt - d0, 32'd1);
        chk("idle_after_done", {31'd0, scan_busy}, 32'd0);
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 2000 && (start_cnt - base) < n; i++) @(negedge clk);
        chk("reach_start_count", start_cnt - base, n);
    endtask

    initial begin
        int d0;
        int s0;
        logic [10:0] ex [6];
        logic [10:0] ey [6];
        ex[0] = 11'd0; ex[1] = 11'd4; ex[2] = 11'd8; ex[3] = 11'd0; ex[4] = 11'd4; ex[5] = 11'd8;
        ey[0] = 11'd0; ey[1] = 11'd0; ey[2] = 11'd0; ey[3] = 11'd1; ey[4] = 11'd1; ey[5] = 11'd1;
        spur_done  = 1'b0;
        rst_n      = 1'b0;
        scan_start = 1'b1;
        set_tbl(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);

        // reset state, scan_start held during reset
        chk("rst_ctrl_outs", {28'd0, fetch_req, sad_start, scan_busy, scan_done}, 32'd0);
        chk("rst_cand", {10'd0, cand_x, cand_y}, 32'd0);
        chk("rst_best_xy", {10'd0, best_x, best_y}, 32'd0);
        chk("rst_best_sad", best_sad, 32'hFFFF_FFFF);
        scan_start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_fetch", {31'd0, fetch_req}, 32'd0);

        // full scan; 40 repeats at (0,1) and must not displace (4,0)
        set_tbl(32'd50, 32'd40, 32'd60, 32'd40, 32'd70, 32'd90);
        d0 = done_cnt;
        begin_scan();
        finish_scan(d0);
        chk("A_start_count", start_cnt - base, 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("A_pos%0d", i), {10'd0, log_x[base+i], log_y[base+i]}, {10'd0, ex[i], ey[i]});
        chk("A_best_sad", best_sad, 32'd40);
        chk("A_best_x", {21'd0, best_x}, 32'd6);
        chk("A_best_y", {21'd0, best_y}, 32'd0);
        repeat (5) @(negedge clk);
        chk("A_best_held", best_sad, 32'd40);

        // fetch stall at (4,0), spurious sad_done in FETCH, scan_start during WAIT
        set_tbl(32'd30, 32'd20, 32'd20, 32'd10, 32'd10, 32'd5);
        stall_en = 1'b1;
        d0 = done_cnt;
        begin_scan();
        s0 = stall_cyc;
        for (int i = 0; i < 500 && !(fetch_req && cand_x == 11'd4 && cand_y == 11'd0); i++) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("B_stall_fetch_req", {31'd0, fetch_req}, 32'd1);
        chk("B_stall_cand_x", {21'd0, cand_x}, 32'd4);
        chk("B_stall_no_start", start_cnt - base, 32'd1);
        wait_starts(3);
        repeat (5) @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        finish_scan(d0);
        stall_en = 1'b0;
        chk("B_stall_cycles", stall_cyc - s0, 32'd10);
        chk("B_start_count", start_cnt - base, 32'd6);
        chk("B_best_sad", best_sad, 32'd5);
        chk("B_best_xy", {10'd0, best_x, best_y}, {10'd0, 11'd10, 11'd1});

        // reset during WAIT of the fourth candidate
        set_tbl(32'd50, 32'd40, 32'd30, 32'd20, 32'd10, 32'd5);
        d0 = done_cnt;
        begin_scan();
        wait_starts(4);
        repeat (10) @(negedge clk);
        chk("C_busy_in_wait", {31'd0, scan_busy}, 32'd1);
        chk("C_best_before_rst", best_sad, 32'd30);
        rst_n = 1'b0;
        @(negedge clk);
        chk("C_rst_busy", {31'd0, scan_busy}, 32'd0);
        chk("C_rst_best_sad", best_sad, 32'hFFFF_FFFF);
        chk("C_rst_best_xy", {10'd0, best_x, best_y}, 32'd0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("C_no_scan_done", done_cnt - d0, 32'd0);
        chk("C_still_idle", {30'd0, scan_busy, fetch_req}, 32'd0);

        // zero SAD at the second candidate
        set_tbl(32'd50, 32'd0, 32'd30, 32'd0, 32'd20, 32'd10);
        d0 = done_cnt;
        begin_scan();
        finish_scan(d0);
        chk("D_best_sad", best_sad, 32'd0);
        chk("D_best_xy", {10'd0, best_x, best_y}, {10'd0, 11'd6, 11'd0});
`ifdef SAD_EARLY_EXIT_EN
        chk("D_start_count", start_cnt - base, 32'd2);
        chk("D_cand_held", {10'd0, cand_x, cand_y}, {10'd0, 11'd4, 11'd0});
`else
        chk("D_start_count", start_cnt - base, 32'd6);
        chk("D_cand_last", {10'd0, cand_x, cand_y}, {10'd0, 11'd8, 11'd1});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
